// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared types and widths for the add_sched block
// Contents:
//   WORD_W  : width of one adder pass
//   DWORD_W : width of a full operand/result
//   state_t : scheduler FSM states
package add_pkg;

  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/add32_ci.sv
// rtl/add32_ci.sv - combinational 32-bit adder with carry-in/carry-out
// Ports:
//   i_a, i_b : 32-bit operands
//   i_ci     : carry-in
//   o_sum    : 32-bit sum
//   o_co     : carry-out of bit 31
module add32_ci
  import add_pkg::*;
(
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic              i_ci,
  output logic [WORD_W-1:0] o_sum,
  output logic              o_co
);

  localparam int NSLICE = WORD_W / 4;

  logic [NSLICE:0] w_c;

  assign w_c[0] = i_ci;

  // Slices are lookahead internally and chained slice-to-slice.
  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    add_cla4 u_cla4 (
      .i_a   (i_a[4*s +: 4]),
      .i_b   (i_b[4*s +: 4]),
      .i_ci  (w_c[s]),
      .o_sum (o_sum[4*s +: 4]),
      .o_co  (w_c[s+1])
    );
  end

  assign o_co = w_c[NSLICE];

endmodule

// File: rtl/add_cla4.sv
// rtl/add_cla4.sv - 4-bit carry-lookahead adder slice
// Ports:
//   i_a, i_b : 4-bit operands
//   i_ci     : carry-in
//   o_sum    : 4-bit sum
//   o_co     : carry-out
module add_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_sum,
  output logic       o_co
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Every internal carry is formed directly from generate/propagate terms.
  assign w_c[0] = i_ci;
  assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);

  assign o_sum = w_p ^ w_c[3:0];
  assign o_co  = w_c[4];

endmodule

// File: rtl/add_sched.sv
// rtl/add_sched.sv - round-robin scheduler sharing one 32-bit adder for 64-bit add/sub
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/req_ready: per-requester handshake (ready is one-hot, IDLE only)
//   req_sub            : per-requester op, 0 = a+b, 1 = a-b
//   req_a, req_b       : packed 64-bit operands, requester i at [64i+63:64i]
//   resp_valid/ready   : result handshake
//   resp_id            : owning requester index
//   resp_sum/carry     : 64-bit result and carry-out of bit 63
module add_sched
  import add_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_sub,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*64-1:0]   req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [DWORD_W-1:0]   resp_sum,
  output logic                 resp_carry
);

  state_t              r_state;
  state_t              w_next;
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      r_id;
  logic                r_sub;
  logic [DWORD_W-1:0]  r_a;
  logic [DWORD_W-1:0]  r_b;
  logic [WORD_W-1:0]   r_sum_lo;
  logic [WORD_W-1:0]   r_sum_hi;
  logic                r_c_lo;
  logic                r_c_hi;

  logic                w_found;
  logic [IDW-1:0]      w_win;
  logic [IDW:0]        w_idx;
  logic [IDW-1:0]      w_ptr_nxt;
  logic                w_accept;
  logic [WORD_W-1:0]   w_b_word;
  logic [WORD_W-1:0]   w_add_a;
  logic [WORD_W-1:0]   w_add_b;
  logic                w_add_ci;
  logic [WORD_W-1:0]   w_add_s;
  logic                w_add_co;

  // Round-robin search: ascending from the pointer, wrapping at NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) begin
        w_idx = w_idx - (IDW+1)'(NREQ);
      end
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  assign w_ptr_nxt  = (w_win == IDW'(NREQ-1)) ? '0 : w_win + IDW'(1);
  assign w_accept   = (r_state == IDLE) && w_found && !rst;
  assign req_ready  = w_accept ? (NREQ'(1) << w_win) : '0;
  assign resp_valid = (r_state == RESP) && !rst;

  // Subtraction is a + ~b + 1: the +1 enters as the low-pass carry-in,
  // the high pass always continues with the registered low carry.
  always_comb begin
    w_add_a  = (r_state == HI) ? r_a[63:32] : r_a[31:0];
    w_b_word = (r_state == HI) ? r_b[63:32] : r_b[31:0];
    w_add_b  = r_sub ? ~w_b_word : w_b_word;
    w_add_ci = (r_state == HI) ? r_c_lo : r_sub;
  end

  add32_ci u_add32_ci (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_ci  (w_add_ci),
    .o_sum (w_add_s),
    .o_co  (w_add_co)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)   w_next = LO;
      LO:                      w_next = HI;
      HI:                      w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_id     <= '0;
      r_sub    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_sum_lo <= '0;
      r_sum_hi <= '0;
      r_c_lo   <= 1'b0;
      r_c_hi   <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id  <= w_win;
            r_sub <= req_sub[w_win];
            r_a   <= req_a[w_win*64 +: 64];
            r_b   <= req_b[w_win*64 +: 64];
            r_ptr <= w_ptr_nxt;
          end
        end
        LO: begin
          r_sum_lo <= w_add_s;
          r_c_lo   <= w_add_co;
        end
        HI: begin
          r_sum_hi <= w_add_s;
          r_c_hi   <= w_add_co;
        end
        default: ;
      endcase
    end
  end

  assign resp_id    = r_id;
  assign resp_sum   = {r_sum_hi, r_sum_lo};
  assign resp_carry = r_c_hi;

endmodule

// File: tb/tb_add_sched.sv
// tb/tb_add_sched.sv - scoreboard testbench for add_sched
module tb_add_sched;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ*64-1:0] req_a;
  logic [NREQ*64-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [63:0]       resp_sum;
  logic              resp_carry;

  logic [63:0] a_arr [NREQ];
  logic [63:0] b_arr [NREQ];

  typedef struct {
    int          id;
    logic [63:0] sum;
    logic        carry;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_grant  = 0;
  int   n_resp   = 0;
  int   m_phase  = 0;
  int   m_ptr    = 0;
  int          last_id;
  logic [63:0] last_sum;
  logic        last_carry;

  add_sched #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sub    (req_sub),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[64*i +: 64] = a_arr[i];
      req_b[64*i +: 64] = b_arr[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: FSM phase, round-robin pointer and scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_rvalid", 64'(resp_valid), 64'd0);
      m_phase = 0;
      m_ptr   = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: begin
          logic [NREQ-1:0] exp_ready;
          int   win;
          bit   found;
          exp_ready = '0;
          win   = 0;
          found = 1'b0;
          for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (!found && req_valid[idx]) begin
              found = 1'b1;
              win   = idx;
            end
          end
          if (found) exp_ready[win] = 1'b1;
          check("grant", 64'(req_ready), 64'(exp_ready));
          check("idle_rvalid", 64'(resp_valid), 64'd0);
          if (found) begin
            exp_t e;
            logic [63:0] a, b;
            a = a_arr[win];
            b = b_arr[win];
            e.id = win;
            if (req_sub[win]) begin
              e.sum   = a - b;
              e.carry = (a >= b);
            end else begin
              e.sum   = a + b;
              e.carry = (e.sum < a);
            end
            exp_q.push_back(e);
            grant_log.push_back(win);
            n_grant++;
            m_ptr   = (win + 1) % NREQ;
            m_phase = 1;
          end
        end
        1, 2: begin
          check("busy_ready", 64'(req_ready), 64'd0);
          check("busy_rvalid", 64'(resp_valid), 64'd0);
          m_phase++;
        end
        default: begin
          check("resp_rvalid", 64'(resp_valid), 64'd1);
          check("resp_ready_blk", 64'(req_ready), 64'd0);
          if (exp_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
          end else begin
            check("resp_id", 64'(resp_id), 64'(exp_q[0].id));
            check("resp_sum", resp_sum, exp_q[0].sum);
            check("resp_carry", 64'(resp_carry), 64'(exp_q[0].carry));
            if (resp_ready) begin
              last_id    = resp_id;
              last_sum   = resp_sum;
              last_carry = resp_carry;
              void'(exp_q.pop_front());
              n_resp++;
              m_phase = 0;
            end
          end
        end
      endcase
    end
  end

  task automatic set_op(input int id, input logic [63:0] a, input logic [63:0] b, input logic sub);
    a_arr[id]   = a;
    b_arr[id]   = b;
    req_sub[id] = sub;
  endtask

  task automatic wait_grant(input int g0);
    int cyc;
    cyc = 0;
    while (n_grant <= g0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (n_grant <= g0) check("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_resp(input int target);
    int cyc;
    cyc = 0;
    while (n_resp < target && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (n_resp < target) check("resp_timeout", 64'(n_resp), 64'(target));
  endtask

  task automatic issue(input int id, input logic [63:0] a, input logic [63:0] b, input logic sub);
    int g0;
    g0 = n_grant;
    set_op(id, a, b, sub);
    req_valid[id] = 1'b1;
    wait_grant(g0);
    req_valid[id] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int r0;
    rst        = 1'b1;
    resp_ready = 1'b1;
    req_valid  = '1;
    req_sub    = '0;
    for (int i = 0; i < NREQ; i++) set_op(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));

    // All requesters valid straight out of reset: strict rotation.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_resp(5);
    req_valid = '0;
    check("rr_count", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check($sformatf("rr_order%0d", i), 64'(grant_log[i]), 64'(i % NREQ));

    // Carry across the word boundary.
    r0 = n_resp;
    issue(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
    wait_resp(r0 + 1);
    check("s1_id", 64'(last_id), 64'd0);
    check("s1_sum", last_sum, 64'h0000_0001_0000_0000);
    check("s1_carry", 64'(last_carry), 64'd0);

    // Full overflow, then a borrowing subtract.
    r0 = n_resp;
    issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    wait_resp(r0 + 1);
    check("s2_sum", last_sum, 64'd0);
    check("s2_carry", 64'(last_carry), 64'd1);
    r0 = n_resp;
    issue(1, 64'd5, 64'd7, 1'b1);
    wait_resp(r0 + 1);
    check("s2_id", 64'(last_id), 64'd1);
    check("s2b_sum", last_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check("s2b_carry", 64'(last_carry), 64'd0);

    // Pointer at 2, only req0 valid: wraps to req0, pointer moves to 1.
    r0 = n_resp;
    issue(0, 64'd100, 64'd40, 1'b1);
    wait_resp(r0 + 1);
    check("wrap_grant", 64'(grant_log[$]), 64'd0);
    check("wrap_sum", last_sum, 64'd60);
    check("wrap_carry", 64'(last_carry), 64'd1);
    g0 = n_grant;
    set_op(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    set_op(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    req_valid[1:0] = 2'b11;
    wait_grant(g0);
    req_valid = '0;
    check("ptr1_grant", 64'(grant_log[$]), 64'd1);
    wait_resp(r0 + 2);

    // Backpressure in RESP: result held, no accept while waiting.
    resp_ready = 1'b0;
    r0 = n_resp;
    issue(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    g0 = n_grant;
    set_op(3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    req_valid[3] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("hold_no_accept", 64'(n_grant), 64'(g0));
    check("hold_no_pop", 64'(n_resp), 64'(r0));
    resp_ready = 1'b1;
    wait_grant(g0);
    req_valid[3] = 1'b0;
    check("hold_next_grant", 64'(grant_log[$]), 64'd3);
    wait_resp(r0 + 2);

    // Reset during HI discards the operation and clears the pointer.
    issue(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    @(posedge clk); #1;
    r0 = n_resp;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_resp", 64'(n_resp), 64'(r0));
    g0 = n_grant;
    set_op(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    set_op(3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    req_valid = 4'b1001;
    wait_grant(g0);
    req_valid = '0;
    check("rst_ptr_grant", 64'(grant_log[$]), 64'd0);
    wait_resp(r0 + 1);
    check("rst_after_sum", last_sum, 64'h2222_2222_2222_2211);
    check("rst_after_carry", 64'(last_carry), 64'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 SHALL have parameter: NREQ, default 4, number of requesters (legal range 2..8).
REQ-002 SHALL derive localparam IDW = max(1, clog2(NREQ)), the width of the requester index.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: req_valid  input  NREQ  per-requester request valid.
REQ-006 SHALL have port: req_ready  output  NREQ  per-requester accept; at most one bit set.
REQ-007 SHALL have port: req_sub  input  NREQ  per-requester op: 0 = a+b, 1 = a-b.
REQ-008 SHALL have port: req_a  input  NREQ*64  per-requester operand A; requester i at bits [64i+63:64i].
REQ-009 SHALL have port: req_b  input  NREQ*64  per-requester operand B, same packing.
REQ-010 SHALL have port: resp_valid  output  1  result valid.
REQ-011 SHALL have port: resp_ready  input  1  result consumer ready.
REQ-012 SHALL have port: resp_id  output  IDW  index of the requester that owns the result.
REQ-013 SHALL have port: resp_sum  output  64  64-bit result, modulo 2^64.
REQ-014 SHALL have port: resp_carry  output  1  carry-out of bit 63 (sub: 1 = no borrow).

Function
REQ-015 SHALL share one 32-bit adder with carry-in among all requesters and run each 64-bit operation as two passes: low word, then high word.
REQ-016 SHALL implement FSM states IDLE, LO, HI, RESP.
REQ-017 State transitions SHALL be IDLE->LO on accept, LO->HI unconditionally, HI->RESP unconditionally, and RESP->IDLE on resp_valid & resp_ready.
REQ-018 SHALL drive req_ready only in IDLE, only for the round-robin winner; req_ready is combinational from req_valid and the priority pointer.
REQ-019 Round-robin SHALL search requester indices starting at the pointer and ascending modulo NREQ; the first index with req_valid set wins.
REQ-020 On accept, SHALL capture operands, op and winner index, and SHALL set the pointer to (winner+1) mod NREQ; the pointer SHALL be unchanged in all other cycles.
REQ-021 Operand handling SHALL be: add uses B and carry-in 0; sub uses ~B and carry-in 1 on the low pass.
REQ-022 LO SHALL register sum[31:0] and the low-pass carry-out; HI SHALL add the high words with that registered carry as carry-in and register sum[63:32] and the carry-out.
REQ-023 Latency SHALL be: accept at cycle T gives resp_valid=1 at T+3; throughput is at most one operation per 4 cycles.
REQ-024 While resp_valid=1 and resp_ready=0, SHALL hold resp_id, resp_sum and resp_carry stable.
REQ-025 resp_valid SHALL be 1 only in RESP.
REQ-026 Requesters that are not granted SHALL be ignored, and SHALL be allowed to drop req_valid before acceptance without effect.
REQ-027 Requesters SHALL NOT be accepted in LO, HI or RESP.
REQ-028 When all requesters are valid every cycle, each SHALL be served once per NREQ operations, with no starvation.

Reset
REQ-029 On rst=1 at a clock edge, SHALL set state to IDLE, pointer to 0 and all captured registers to 0.
REQ-030 During reset, req_ready SHALL be 0 and resp_valid SHALL be 0.
REQ-031 Reset asserted mid-operation (LO/HI/RESP) SHALL discard the in-flight transaction, with no response issued.

Structure
REQ-032 Package add_pkg SHALL hold the FSM state type and the constants WORD_W=32 and DWORD_W=64.
REQ-033 Sub-module add32_ci SHALL be a combinational 32-bit adder with carry-in and carry-out, built from the team's 4-bit carry-lookahead slices; exactly one instance.

Verification
REQ-034 Scenario: req0: a=0x0000_0000_FFFF_FFFF, b=1, add -> at T+3, resp_id=0, resp_sum=0x0000_0001_0000_0000, resp_carry=0.
REQ-035 Scenario: req1: a=0xFFFF_FFFF_FFFF_FFFF, b=1, add -> resp_sum=0, resp_carry=1; then sub a=5, b=7 -> resp_sum=0xFFFF_FFFF_FFFF_FFFE, resp_carry=0.
REQ-036 Scenario: all 4 req_valid held high from reset -> grants in order 0,1,2,3,0; the req_ready one-hot is observed in IDLE cycles only.
REQ-037 Scenario: resp_ready held 0 for 5 cycles in RESP -> outputs stable, no new accept; resp_ready=1 -> IDLE the next cycle.
REQ-038 Scenario: rst pulsed during HI -> no resp_valid, pointer=0, and the next accepted request completes correctly.
REQ-039 Scenario: pointer=2 with only req0 valid -> req0 granted and pointer becomes 1.
